ptpv2_apb_arbiter: RTL and testbench
====================================

// Module: ptpv2_apb_arbiter
// PURPOSE
//  Two-requester APB arbiter that shares the single APB CSR slave port of the
//  gig_eth_ptpv2_lite core. Requester 0 is the host CPU (config/MAC/enables).
//  Requester 1 is the PTP servo (RTC ToD/increment adjust).
//  Round-robin grant, one downstream transfer at a time. Multi-word ToD/INC
//  updates can optionally be kept atomic with a lock.
// PARAMETERS
//  AW        32  address width, all PADDR ports
//  DW        32  data width, all PWDATA/PRDATA ports
//  LOCK_MAX  16  idle cycles after which a held lock is forcibly released (>=1)
// PORTS  (x = 0,1; Sx_* = upstream slave side, M_* = downstream master side)
//  PCLK         in   1   clock, all logic on rising edge
//  PRESETn      in   1   synchronous active-low reset
//  Sx_PSEL      in   1   requester x select
//  Sx_PENABLE   in   1   requester x access phase
//  Sx_PADDR     in   AW  requester x address
//  Sx_PWRITE    in   1   requester x write=1/read=0
//  Sx_PWDATA    in   DW  requester x write data
//  Sx_PLOCK     in   1   requester x: keep grant after this transfer
//  Sx_PREADY    out  1   requester x transfer complete (1-cycle pulse)
//  Sx_PRDATA    out  DW  requester x read data, valid while Sx_PREADY=1
//  M_PSEL       out  1   to core PSEL
//  M_PENABLE    out  1   to core PENABLE
//  M_PADDR      out  AW  to core PADDR
//  M_PWRITE     out  1   to core PWRITE
//  M_PWDATA     out  DW  to core PWDATA
//  M_PRDATA     in   DW  from core PRDATA; core has no PREADY, zero wait state
//  GRANT        out  2   one-hot current owner, 2'b00 when idle
// BEHAVIOUR
//  Reset (PRESETn=0 at posedge)
//   - all outputs 0; FSM->IDLE; last-grant pointer=1 (S0 wins first tie);
//     lock cleared, idle counter 0.
//   - Asserted mid-transfer: downstream access abandoned, no Sx_PREADY issued.
//  Request: Sx_PSEL=1 (PENABLE value irrelevant for arbitration).
//  FSM
//   IDLE   - No request: stay.
//          - Else grant w: locked owner if lock set; else the sole requester;
//            else (both) the requester != last-grant pointer.
//          - Latch Sx_PADDR/PWRITE/PWDATA/PLOCK of w; GRANT=onehot(w); ->SETUP.
//   SETUP  - M_PSEL=1, M_PENABLE=0, M_PADDR/PWRITE/PWDATA=latched; ->ACCESS.
//   ACCESS - M_PSEL=1, M_PENABLE=1; register M_PRDATA at this edge; ->RESP.
//   RESP   - M_PSEL=M_PENABLE=0; Sw_PREADY=1 one cycle; Sw_PRDATA=registered.
//          - Pointer<=w; lock<=latched PLOCK (macro on); GRANT->0; ->IDLE.
//  Latency: request seen in IDLE at cycle n -> Sw_PREADY at cycle n+3.
//   4 cycles per transfer; back-to-back from one requester every 4 cycles.
//  Fairness: with both requesting continuously, grants alternate 0,1,0,1...
//  Sx_PRDATA is 0 whenever Sx_PREADY=0; write transfers also return registered
//   M_PRDATA (don't care).
//  Requester drops PSEL after grant (protocol error): transfer still completes
//   downstream with latched values; PREADY still pulsed.
//  Latched values are immune to upstream changes after IDLE.
//  Downstream outputs hold 0 in IDLE/RESP (no address leakage).
// CONFIGURATION
//  PTPV2_ARB_LOCK_EN defined:
//   - Transfer completed with Sx_PLOCK=1 sets lock to x; only x is granted in
//     IDLE until x completes a transfer with PLOCK=0.
//   - While locked and in IDLE with Sx_PSEL=0, idle counter increments; at
//     LOCK_MAX lock clears, counter resets; counter resets on every owner grant.
//  PTPV2_ARB_LOCK_EN undefined:
//   - Sx_PLOCK ignored, no lock/counter logic; pure round-robin.
// TESTING
//  1 Reset: PRESETn=0 for 5 cycles mid-transfer -> all outputs 0, no PREADY,
//    next S0 request served normally.
//  2 Single: S0 write 0x0000_0010<=0x1234_5678 -> M_PSEL at n+1, M_PENABLE at
//    n+2, S0_PREADY at n+3; S0 readback returns 0x1234_5678.
//  3 Tie: S0 and S1 request same cycle after reset -> S0 granted first, S1 next
//    at 4-cycle spacing; 8 continuous requests each -> strict alternation.
//  4 Lock (macro on): S1 writes ToD hi (PLOCK=1), lo (PLOCK=1), ctrl (PLOCK=0)
//    with S0 pending -> three S1 transfers consecutive, then S0.
//  5 Lock timeout (macro on): S1 locks then idles, S0 pending -> S0 granted
//    after LOCK_MAX=16 idle cycles, not before. Macro off: S0 granted next.
//  6 Abort: S1 drops PSEL in SETUP -> downstream access still issued;
//    S1_PREADY pulses; S0 unaffected.

Source files
------------

// File: rtl/ptpv2_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : ptpv2_apb_arbiter
// Description: Round-robin arbiter sharing one zero-wait-state APB CSR slave
//              between the host CPU (S0) and the PTP servo (S1). Optional
//              grant lock, enabled by defining PTPV2_ARB_LOCK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module ptpv2_apb_arbiter #(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int LOCK_MAX = 16
) (
    input  logic          PCLK,
    input  logic          PRESETn,
    input  logic          S0_PSEL,
    input  logic          S0_PENABLE,
    input  logic [AW-1:0] S0_PADDR,
    input  logic          S0_PWRITE,
    input  logic [DW-1:0] S0_PWDATA,
    input  logic          S0_PLOCK,
    output logic          S0_PREADY,
    output logic [DW-1:0] S0_PRDATA,
    input  logic          S1_PSEL,
    input  logic          S1_PENABLE,
    input  logic [AW-1:0] S1_PADDR,
    input  logic          S1_PWRITE,
    input  logic [DW-1:0] S1_PWDATA,
    input  logic          S1_PLOCK,
    output logic          S1_PREADY,
    output logic [DW-1:0] S1_PRDATA,
    output logic          M_PSEL,
    output logic          M_PENABLE,
    output logic [AW-1:0] M_PADDR,
    output logic          M_PWRITE,
    output logic [DW-1:0] M_PWDATA,
    input  logic [DW-1:0] M_PRDATA,
    output logic [1:0]    GRANT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t        state_q;
    logic          owner_q;
    logic          ptr_q;
    logic          m_psel_q;
    logic          m_penable_q;
    logic [AW-1:0] m_paddr_q;
    logic          m_pwrite_q;
    logic [DW-1:0] m_pwdata_q;
    logic [1:0]    grant_q;
    logic          s0_pready_q;
    logic          s1_pready_q;
    logic [DW-1:0] s0_prdata_q;
    logic [DW-1:0] s1_prdata_q;

    logic          w_req;
    logic          w_win;
    logic [AW-1:0] w_paddr;
    logic          w_pwrite;
    logic [DW-1:0] w_pwdata;

`ifdef PTPV2_ARB_LOCK_EN
    localparam int CW = $clog2(LOCK_MAX + 1);

    logic          plock_q;
    logic          lock_q;
    logic          lock_owner_q;
    logic [CW-1:0] idle_cnt_q;
    logic          w_plock;
    logic          w_unused;

    assign w_plock  = w_win ? S1_PLOCK : S0_PLOCK;
    assign w_unused = ^{S0_PENABLE, S1_PENABLE};
`else
    logic          w_unused;

    assign w_unused = ^{S0_PENABLE, S1_PENABLE, S0_PLOCK, S1_PLOCK, (LOCK_MAX > 0)};
`endif

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_req = S0_PSEL | S1_PSEL;
        w_win = (S0_PSEL && S1_PSEL) ? ~ptr_q : S1_PSEL;
`ifdef PTPV2_ARB_LOCK_EN
        if (lock_q) begin
            w_win = lock_owner_q;
            w_req = lock_owner_q ? S1_PSEL : S0_PSEL;
        end
`endif
    end

    assign w_paddr  = w_win ? S1_PADDR  : S0_PADDR;
    assign w_pwrite = w_win ? S1_PWRITE : S0_PWRITE;
    assign w_pwdata = w_win ? S1_PWDATA : S0_PWDATA;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            ptr_q       <= 1'b1;
            m_psel_q    <= 1'b0;
            m_penable_q <= 1'b0;
            m_paddr_q   <= '0;
            m_pwrite_q  <= 1'b0;
            m_pwdata_q  <= '0;
            grant_q     <= 2'b00;
            s0_pready_q <= 1'b0;
            s1_pready_q <= 1'b0;
            s0_prdata_q <= '0;
            s1_prdata_q <= '0;
`ifdef PTPV2_ARB_LOCK_EN
            plock_q      <= 1'b0;
            lock_q       <= 1'b0;
            lock_owner_q <= 1'b0;
            idle_cnt_q   <= '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_req) begin
                        owner_q    <= w_win;
                        m_psel_q   <= 1'b1;
                        m_paddr_q  <= w_paddr;
                        m_pwrite_q <= w_pwrite;
                        m_pwdata_q <= w_pwdata;
                        grant_q    <= w_win ? 2'b10 : 2'b01;
                        state_q    <= ST_SETUP;
`ifdef PTPV2_ARB_LOCK_EN
                        plock_q    <= w_plock;
                        idle_cnt_q <= '0;
`endif
                    end
`ifdef PTPV2_ARB_LOCK_EN
                    // Owner went quiet while holding the lock: time it out.
                    else if (lock_q) begin
                        if (idle_cnt_q == CW'(LOCK_MAX - 1)) begin
                            lock_q     <= 1'b0;
                            idle_cnt_q <= '0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
`endif
                end
                ST_SETUP: begin
                    m_penable_q <= 1'b1;
                    state_q     <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    m_psel_q    <= 1'b0;
                    m_penable_q <= 1'b0;
                    m_paddr_q   <= '0;
                    m_pwrite_q  <= 1'b0;
                    m_pwdata_q  <= '0;
                    if (owner_q) begin
                        s1_pready_q <= 1'b1;
                        s1_prdata_q <= M_PRDATA;
                    end else begin
                        s0_pready_q <= 1'b1;
                        s0_prdata_q <= M_PRDATA;
                    end
                    state_q <= ST_RESP;
                end
                default: begin
                    s0_pready_q <= 1'b0;
                    s1_pready_q <= 1'b0;
                    s0_prdata_q <= '0;
                    s1_prdata_q <= '0;
                    grant_q     <= 2'b00;
                    ptr_q       <= owner_q;
`ifdef PTPV2_ARB_LOCK_EN
                    lock_q       <= plock_q;
                    lock_owner_q <= owner_q;
                    idle_cnt_q   <= '0;
`endif
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign M_PSEL    = m_psel_q;
    assign M_PENABLE = m_penable_q;
    assign M_PADDR   = m_paddr_q;
    assign M_PWRITE  = m_pwrite_q;
    assign M_PWDATA  = m_pwdata_q;
    assign GRANT     = grant_q;
    assign S0_PREADY = s0_pready_q;
    assign S1_PREADY = s1_pready_q;
    assign S0_PRDATA = s0_prdata_q;
    assign S1_PRDATA = s1_prdata_q;

endmodule
`default_nettype wire

// File: tb/tb_ptpv2_apb_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : tb_ptpv2_apb_arbiter
// Description: Scoreboard bench for ptpv2_apb_arbiter with a zero-wait memory
//              model on the downstream port. Follows PTPV2_ARB_LOCK_EN.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_ptpv2_apb_arbiter;

    logic        clk;
    logic        rst_n;
    logic        psel    [2];
    logic        penable [2];
    logic [31:0] paddr   [2];
    logic        pwrite  [2];
    logic [31:0] pwdata  [2];
    logic        plock   [2];
    logic        pready  [2];
    logic [31:0] prdata  [2];
    logic        M_PSEL, M_PENABLE, M_PWRITE;
    logic [31:0] M_PADDR, M_PWDATA, M_PRDATA;
    logic [1:0]  GRANT;

    logic [31:0] mem [16];

    typedef struct {
        int          who;
        bit          chk;
        logic [31:0] data;
        int          gap;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_cyc = 0;

    ptpv2_apb_arbiter #(.AW(32), .DW(32), .LOCK_MAX(16)) dut (
        .PCLK(clk), .PRESETn(rst_n),
        .S0_PSEL(psel[0]), .S0_PENABLE(penable[0]), .S0_PADDR(paddr[0]),
        .S0_PWRITE(pwrite[0]), .S0_PWDATA(pwdata[0]), .S0_PLOCK(plock[0]),
        .S0_PREADY(pready[0]), .S0_PRDATA(prdata[0]),
        .S1_PSEL(psel[1]), .S1_PENABLE(penable[1]), .S1_PADDR(paddr[1]),
        .S1_PWRITE(pwrite[1]), .S1_PWDATA(pwdata[1]), .S1_PLOCK(plock[1]),
        .S1_PREADY(pready[1]), .S1_PRDATA(prdata[1]),
        .M_PSEL(M_PSEL), .M_PENABLE(M_PENABLE), .M_PADDR(M_PADDR),
        .M_PWRITE(M_PWRITE), .M_PWDATA(M_PWDATA), .M_PRDATA(M_PRDATA),
        .GRANT(GRANT)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream core model: zero wait state register file.
    assign M_PRDATA = mem[M_PADDR[5:2]];
    always @(posedge clk) begin
        if (M_PSEL && M_PENABLE && M_PWRITE) mem[M_PADDR[5:2]] <= M_PWDATA;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic void expect_rsp(input int who, input bit chk, input logic [31:0] d, input int gap);
        exp_t e;
        e.who = who; e.chk = chk; e.data = d; e.gap = gap;
        sb.push_back(e);
    endfunction

    function automatic logic [31:0] all_out();
        return {31'd0, |{GRANT, M_PSEL, M_PENABLE, M_PADDR, M_PWRITE, M_PWDATA,
                         pready[0], pready[1], prdata[0], prdata[1]}};
    endfunction

    // Monitor: every PREADY pulse is matched against the next expected response.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (pready[0] || pready[1]) begin
                if (sb.size() == 0) begin
                    check("unexpected_pready", {30'd0, pready[1], pready[0]}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("rsp_owner", pready[1] ? 32'd1 : 32'd0, e.who);
                    check("idle_side_prdata", prdata[1 - e.who], 32'd0);
                    if (e.chk) check("rsp_rdata", prdata[e.who], e.data);
                    if (e.gap != 0) check("rsp_spacing", cyc - last_cyc, e.gap);
                end
                last_cyc = cyc;
            end
        end
    end

    task automatic req(input int x, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic lk);
        bit done;
        done = 1'b0;
        psel[x] = 1'b1; penable[x] = 1'b0; paddr[x] = a;
        pwrite[x] = w; pwdata[x] = d; plock[x] = lk;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            penable[x] = 1'b1;
            if (pready[x]) done = 1'b1;
        end
        if (!done) check("req_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        psel[x] = 1'b0; penable[x] = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 32'd0;
        for (int i = 0; i < 2; i++) begin
            psel[i] = 1'b0; penable[i] = 1'b0; paddr[i] = '0;
            pwrite[i] = 1'b0; pwdata[i] = '0; plock[i] = 1'b0;
        end
        do_reset(3);
        check("reset_outputs", all_out(), 32'd0);

        // Reset arriving while S1 is in SETUP abandons the transfer.
        @(posedge clk); #1;
        psel[1] = 1'b1; paddr[1] = 32'h20; pwrite[1] = 1'b1; pwdata[1] = 32'hDEAD_0000;
        @(posedge clk); #1;
        rst_n = 1'b0; psel[1] = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("midreset_outputs", all_out(), 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Single S0 write with cycle-accurate latency, then readback.
        expect_rsp(0, 1'b0, 32'h0, 0);
        fork
            req(0, 32'h10, 1'b1, 32'h1234_5678, 1'b0);
            begin
                @(negedge clk);
                check("n_psel", {31'd0, M_PSEL}, 32'd0);
                @(negedge clk);
                check("n1_psel", {31'd0, M_PSEL}, 32'd1);
                check("n1_penable", {31'd0, M_PENABLE}, 32'd0);
                check("n1_paddr", M_PADDR, 32'h10);
                check("n1_pwdata", M_PWDATA, 32'h1234_5678);
                check("n1_grant", {30'd0, GRANT}, 32'd1);
                @(negedge clk);
                check("n2_penable", {31'd0, M_PENABLE}, 32'd1);
                @(negedge clk);
                check("n3_pready", {31'd0, pready[0]}, 32'd1);
                check("n3_paddr_clear", M_PADDR, 32'd0);
            end
        join
        expect_rsp(0, 1'b1, 32'h1234_5678, 4);
        req(0, 32'h10, 1'b0, 32'h0, 1'b0);

        // Tie after reset: S0 first, then strict alternation.
        do_reset(2);
        @(posedge clk); #1;
        for (int i = 0; i < 8; i++) begin
            expect_rsp(0, 1'b1, 32'h1234_5678, (i == 0) ? 0 : 4);
            expect_rsp(1, 1'b1, 32'h0, 4);
        end
        fork
            for (int i = 0; i < 8; i++) req(0, 32'h10, 1'b0, 32'h0, 1'b0);
            for (int i = 0; i < 8; i++) req(1, 32'h20, 1'b0, 32'h0, 1'b0);
        join

        // Multi-word ToD update from S1 with S0 pending.
`ifdef PTPV2_ARB_LOCK_EN
        expect_rsp(1, 1'b0, 32'h0, 0);
        expect_rsp(1, 1'b0, 32'h0, 4);
        expect_rsp(1, 1'b0, 32'h0, 4);
        expect_rsp(0, 1'b1, 32'hAAAA_0001, 4);
`else
        expect_rsp(1, 1'b0, 32'h0, 0);
        expect_rsp(0, 1'b1, 32'hAAAA_0001, 4);
        expect_rsp(1, 1'b0, 32'h0, 4);
        expect_rsp(1, 1'b0, 32'h0, 4);
`endif
        fork
            begin
                req(1, 32'h30, 1'b1, 32'hAAAA_0001, 1'b1);
                req(1, 32'h34, 1'b1, 32'h5555_0002, 1'b1);
                req(1, 32'h38, 1'b1, 32'h0000_0001, 1'b0);
            end
            begin
                @(posedge clk); #1;
                req(0, 32'h30, 1'b0, 32'h0, 1'b0);
            end
        join

        // S1 takes the lock and goes idle while S0 waits.
        expect_rsp(1, 1'b0, 32'h0, 0);
`ifdef PTPV2_ARB_LOCK_EN
        expect_rsp(0, 1'b1, 32'h0000_7777, 20);
`else
        expect_rsp(0, 1'b1, 32'h0000_7777, 4);
`endif
        fork
            req(1, 32'h3C, 1'b1, 32'h0000_7777, 1'b1);
            begin
                @(posedge clk); #1;
                req(0, 32'h3C, 1'b0, 32'h0, 1'b0);
            end
        join

        // S1 abandons its request in SETUP; the latched write still lands.
        expect_rsp(1, 1'b0, 32'h0, 0);
        expect_rsp(0, 1'b1, 32'h0BAD_F00D, 4);
        fork
            begin
                psel[1] = 1'b1; paddr[1] = 32'h2C; pwrite[1] = 1'b1;
                pwdata[1] = 32'h0BAD_F00D; plock[1] = 1'b0;
                @(posedge clk); #1;
                psel[1] = 1'b0; paddr[1] = 32'hFFFF_FFFC; pwdata[1] = 32'h0;
                @(negedge clk);
                check("abort_setup_paddr", M_PADDR, 32'h2C);
            end
            req(0, 32'h2C, 1'b0, 32'h0, 1'b0);
        join

        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
